// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing the UART TX FIFO write port among N_REQ byte streams.
// Define UART_ARB_TAG_EN to prefix every grant with a channel tag byte (TAG_BASE | index).
module uart_tx_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned TAG_BASE  = 8'hF0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         w_data,
   output logic               w_uart,
   input  logic               tx_fifo_full,
   output logic [N_REQ-1:0]   grant,
   output logic               busy
);

   localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CAND_W = IDX_W + 1;
   localparam int unsigned CNT_W  = 8;

`ifdef UART_ARB_TAG_EN
   typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, XFER = 2'd2} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;
`endif

   generate
      if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || TAG_BASE > 255) begin : g_bad_param
         $error("uart_tx_arbiter: parameter out of range");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               busy_d;

   logic [7:0]         data_arr [N_REQ];
   logic [IDX_W-1:0]   win_idx;
   logic [CAND_W-1:0]  cand;
   logic               any_req;
   logic               sel_valid;
   logic               sel_last;
   logic [7:0]         sel_data;
   logic               xfer;

   // Unpacked view of the request bytes for indexed selection
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[8*i +: 8];
   end

   assign sel_valid = req_valid[gidx_q];
   assign sel_last  = req_last[gidx_q];
   assign sel_data  = data_arr[gidx_q];

   // First valid requester scanning ptr+1, ptr+2, ... modulo N_REQ
   always_comb begin
      win_idx = ptr_q;
      any_req = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = CAND_W'(ptr_q) + CAND_W'(k);
         if (cand >= CAND_W'(N_REQ)) cand = cand - CAND_W'(N_REQ);
         if (!any_req && req_valid[IDX_W'(cand)]) begin
            win_idx = IDX_W'(cand);
            any_req = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant   <= '0;
         gidx_q  <= '0;
         ptr_q   <= IDX_W'(N_REQ - 1);
         count_q <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         busy    <= busy_d;
      end
   end

   // Next state and the zero-latency write-port outputs
   always_comb begin
      state_d   = state_q;
      grant_d   = grant;
      gidx_d    = gidx_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      busy_d    = busy;
      req_ready = '0;
      w_uart    = 1'b0;
      w_data    = '0;
      xfer      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
`ifdef UART_ARB_TAG_EN
               state_d = TAG;
`else
               state_d = XFER;
`endif
               grant_d = N_REQ'(1) << win_idx;
               gidx_d  = win_idx;
               ptr_d   = win_idx;
               count_d = '0;
               busy_d  = 1'b1;
            end
         end
`ifdef UART_ARB_TAG_EN
         TAG: begin
            w_uart = ~tx_fifo_full;
            w_data = 8'(TAG_BASE) | 8'(gidx_q);
            if (!tx_fifo_full) state_d = XFER;
         end
`endif
         XFER: begin
            xfer              = sel_valid & ~tx_fifo_full;
            req_ready[gidx_q] = xfer;
            w_uart            = xfer;
            w_data            = sel_data;
            if (xfer) begin
               count_d = count_q + CNT_W'(1);
               // Packet end or burst cap releases the grant
               if (sel_last || count_d == CNT_W'(MAX_BURST)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, write log, per-scenario checks.
module tb_uart_tx_arbiter;
   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*N-1:0] req_data;
   logic [7:0]     w_data;
   logic           w_uart, tx_fifo_full, busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] src_q [N][$];
   logic [7:0] wr_q [$];

   uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(4), .TAG_BASE(8'hF0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .w_data(w_data), .w_uart(w_uart),
      .tx_fifo_full(tx_fifo_full), .grant(grant), .busy(busy));

   always #5 clk = ~clk;

   // Requester models: present queue head 1ns after each rising edge
   initial begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            logic [8:0] b;
            b = (src_q[i].size() > 0) ? src_q[i][0] : 9'h000;
            req_valid[i]      = (src_q[i].size() > 0);
            req_last[i]       = b[8];
            req_data[8*i +: 8] = b[7:0];
         end
      end
   end

   // Write-port log and handshake consumption, mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (w_uart === 1'b1) wr_q.push_back(w_data);
         for (int i = 0; i < N; i++)
            if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1 && src_q[i].size() > 0)
               src_q[i].delete(0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_until_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         bit empty;
         tick();
         empty = 1'b1;
         for (int i = 0; i < N; i++) if (src_q[i].size() != 0) empty = 1'b0;
         if (empty && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tx_fifo_full = 1'b0;
      tick(); tick();
      n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (w_uart !== 1'b0) begin n_fail++; $display("FAIL reset_w_uart: got %b expected 0", w_uart); end
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_tests++; if (w_data !== 8'h00) begin n_fail++; $display("FAIL reset_w_data: got %h expected 00", w_data); end
      reset = 1'b1;
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single();
      logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
      wr_q.delete();
      src_q[0].push_back({1'b0, 8'h41});
      src_q[0].push_back({1'b0, 8'h42});
      src_q[0].push_back({1'b1, 8'h43});
      tick();
      @(negedge clk);
      n_tests++; if ({grant, w_uart} !== 5'b0) begin n_fail++; $display("FAIL single_arb: got grant=%b w_uart=%b expected 0000/0", grant, w_uart); end
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         n_tests++;
         if (grant !== 4'b0001 || w_uart !== 1'b1 || w_data !== exp[i] || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_byte%0d: got grant=%b w_uart=%b w_data=%h ready=%b expected 0001/1/%h/0001",
                     i, grant, w_uart, w_data, req_ready, exp[i]);
         end
      end
      tick();
      @(negedge clk);
      n_tests++; if ({grant, busy, w_uart} !== 6'b0) begin n_fail++; $display("FAIL single_release: got grant=%b busy=%b w_uart=%b expected 0000/0/0", grant, busy, w_uart); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
      logic [7:0] exp_w [8] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      wr_q.delete();
      for (int r = 0; r < 2; r++) begin
         src_q[0].push_back({1'b0, (r == 0) ? 8'hA0 : 8'hC0});
         src_q[0].push_back({1'b1, (r == 0) ? 8'hA1 : 8'hC1});
         src_q[1].push_back({1'b0, (r == 0) ? 8'hB0 : 8'hD0});
         src_q[1].push_back({1'b1, (r == 0) ? 8'hB1 : 8'hD1});
         for (int c = 0; c < 7; c++) begin
            tick();
            n_tests++;
            if (grant !== exp_g[c]) begin
               n_fail++;
               $display("FAIL rr_round%0d_cycle%0d_grant: got %b expected %b", r, c, grant, exp_g[c]);
            end
         end
      end
      n_tests++; if (wr_q.size() != 8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", wr_q.size()); end
      for (int i = 0; i < 8; i++) begin
         logic [7:0] got;
         got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
         n_tests++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL rr_byte%0d: got %h expected %h", i, got, exp_w[i]); end
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
      bit ok;
      wr_q.delete();
      for (int i = 0; i < 4; i++) src_q[0].push_back({(i == 3), exp[i]});
      tick(); tick(); tick(); tick();
      tx_fifo_full = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         n_tests++;
         if (w_uart !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_cycle%0d: got w_uart=%b ready=%b grant=%b expected 0/0000/0001", s, w_uart, req_ready, grant);
         end
         tick();
      end
      tx_fifo_full = 1'b0;
      @(negedge clk);
      n_tests++; if (w_uart !== 1'b1 || w_data !== 8'h12) begin n_fail++; $display("FAIL stall_resume: got w_uart=%b w_data=%h expected 1/12", w_uart, w_data); end
      run_until_idle(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got busy expected idle"); end
      n_tests++; if (wr_q.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", wr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] got;
         got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
         n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_burst();
      logic [7:0] exp [8] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h24, 8'h25};
      bit ok;
      wr_q.delete();
      for (int i = 0; i < 6; i++) src_q[2].push_back({(i == 5), 8'(8'h20 + i)});
      src_q[3].push_back({1'b0, 8'h30});
      src_q[3].push_back({1'b1, 8'h31});
      run_until_idle(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL burst_timeout: got busy expected idle"); end
      n_tests++; if (wr_q.size() != 8) begin n_fail++; $display("FAIL burst_count: got %0d expected 8", wr_q.size()); end
      for (int i = 0; i < 8; i++) begin
         logic [7:0] got;
         got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
         n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [3] = '{8'h50, 8'h51, 8'h77};
      bit ok;
      bit seen;
      wr_q.delete();
      for (int i = 0; i < 5; i++) src_q[0].push_back({(i == 4), 8'(8'h50 + i)});
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (wr_q.size() >= 2) seen = 1'b1;
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_wait: got %0d writes expected 2", wr_q.size()); end
      reset = 1'b0;
      #1;
      n_tests++;
      if (grant !== 4'b0000 || busy !== 1'b0 || w_uart !== 1'b0 || req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstmid_drop: got grant=%b busy=%b w_uart=%b ready=%b expected 0000/0/0/0000", grant, busy, w_uart, req_ready);
      end
      src_q[0].delete();
      tick(); tick();
      reset = 1'b1;
      src_q[1].push_back({1'b1, 8'h77});
      tick();
      @(negedge clk);
      n_tests++; if (grant !== 4'b0000 || w_uart !== 1'b0) begin n_fail++; $display("FAIL rstmid_arb: got grant=%b w_uart=%b expected 0000/0", grant, w_uart); end
      tick();
      @(negedge clk);
      n_tests++;
      if (grant !== 4'b0010 || w_uart !== 1'b1 || w_data !== 8'h77) begin
         n_fail++;
         $display("FAIL rstmid_grant1: got grant=%b w_uart=%b w_data=%h expected 0010/1/77", grant, w_uart, w_data);
      end
      run_until_idle(ok);
      n_tests++; if (!ok || wr_q.size() != 3) begin n_fail++; $display("FAIL rstmid_count: got %0d writes expected 3", wr_q.size()); end
      for (int i = 0; i < 3; i++) begin
         logic [7:0] got;
         got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
         n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_tag();
`ifdef UART_ARB_TAG_EN
      logic [7:0] exp [$] = '{8'hF1, 8'h55};
`else
      logic [7:0] exp [$] = '{8'h55};
`endif
      bit ok;
      wr_q.delete();
      src_q[1].push_back({1'b1, 8'h55});
      run_until_idle(ok);
      n_tests++; if (!ok || wr_q.size() != exp.size()) begin n_fail++; $display("FAIL tag_count: got %0d expected %0d", wr_q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] got;
         got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
         n_tests++; if (got !== exp[i]) begin n_fail++; $display("FAIL tag_byte%0d: got %h expected %h", i, got, exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_burst();
      test_reset_mid();
      test_tag();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
